// File: rtl/fc_pkg.sv
// fc_pkg: shared state encoding and default sizing for the fc MAC arbiter
package fc_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} arb_state_t;
  localparam int DEF_N_REQ = 2;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_MAC_LAT = 3;
endpackage

// File: rtl/fc_rr_picker.sv
// fc_rr_picker: rotate-priority encoder, nearest requester after last_grant wins
module fc_rr_picker #(
  parameter int N_REQ = 2,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] pick,
  output logic             any
);
  // scan farthest to nearest so the nearest asserted requester overwrites
  always_comb begin
    pick = '0;
    for (int i = N_REQ; i >= 1; i--)
      if (req[(int'(last_grant) + i) % N_REQ]) pick = N_REQ'(1) << ((int'(last_grant) + i) % N_REQ);
  end
  assign any = |req;
endmodule

// File: rtl/fc_mac_arbiter.sv
// fc_mac_arbiter: round-robin job scheduler sharing one saturating MAC between fc controllers
module fc_mac_arbiter
  import fc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ,
  parameter int LEN_W = 8,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int RELU = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0]             op_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0]  op_a,
  input  logic [N_REQ-1:0][WIDTH-1:0]  op_b,
  output logic [N_REQ-1:0]             op_ready,
  output logic [N_REQ-1:0]             res_valid,
  output logic [WIDTH-1:0]             res_data,
  input  logic [N_REQ-1:0]             res_ready,
  output logic                         mac_clear,
  output logic [WIDTH-1:0]             mac_a,
  output logic [WIDTH-1:0]             mac_b,
  output logic                         mac_valid_in,
  input  logic [WIDTH-1:0]             mac_f
);
  localparam int IW = $clog2(N_REQ);
  localparam int DW = $clog2(MAC_LAT + 1);
  arb_state_t state;
  logic [IW-1:0] g, last_grant, pick_idx;
  logic [LEN_W-1:0] len;
  logic [LEN_W:0] cnt;
  logic [DW-1:0] dcnt;
  logic [WIDTH-1:0] res_q;
  logic [N_REQ-1:0] pick, onehot_g;
  logic any;
  fc_rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req(req_valid),
    .last_grant(last_grant),
    .pick(pick),
    .any(any)
  );
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick[i]) pick_idx = IW'(i);
  end
  assign onehot_g = N_REQ'(1) << g;
  // grant is gated by reset so nothing is offered while the block is held in reset
  assign req_ready = (state == IDLE && !reset) ? pick : '0;
  assign op_ready = state == STREAM ? onehot_g : '0;
  assign res_valid = state == RESULT ? onehot_g : '0;
  assign res_data = state == RESULT ? res_q : '0;
  assign mac_valid_in = state == STREAM && op_valid[g];
  assign mac_a = state == STREAM ? op_a[g] : '0;
  assign mac_b = state == STREAM ? op_b[g] : '0;
  assign mac_clear = reset || state == CLEAR;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      g <= '0;
      len <= '0;
      cnt <= '0;
      dcnt <= '0;
      last_grant <= IW'(N_REQ - 1);
      res_q <= '0;
    end else
      case (state)
        IDLE: if (any) begin
          g <= pick_idx;
          len <= req_len[pick_idx];
          state <= CLEAR;
        end
        CLEAR: begin
          cnt <= '0;
          dcnt <= DW'(MAC_LAT);
          state <= len == '0 ? DRAIN : STREAM;
        end
        STREAM: if (op_valid[g]) begin
          cnt <= cnt + 1'b1;
          if (cnt + 1'b1 == {1'b0, len}) begin
            dcnt <= DW'(MAC_LAT);
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dcnt <= dcnt - 1'b1;
          if (dcnt == DW'(1)) begin
            res_q <= (RELU != 0 && mac_f[WIDTH-1]) ? '0 : mac_f;
            state <= RESULT;
          end
        end
        RESULT: if (res_ready[g]) begin
          last_grant <= g;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fc_mac_arbiter.sv
// tb_fc_mac_arbiter: directed jobs through a ReLU and a non-ReLU arbiter, each driving its own saturating MAC model
module tb_fc_mac_arbiter;
  localparam int MAC_LAT = 3;
  logic clk, reset;
  logic [1:0] req_valid, op_valid, res_ready;
  logic [1:0][7:0] req_len;
  logic [1:0][15:0] op_a, op_b;
  logic [1:0] req_ready, op_ready, res_valid, req_ready_nr, op_ready_nr, res_valid_nr;
  logic [15:0] res_data, res_data_nr;
  logic [1:0] mclr, mvi;
  logic [1:0][15:0] ma, mb, mf, acc, p1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  fc_mac_arbiter #(.RELU(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .mac_clear(mclr[0]), .mac_a(ma[0]), .mac_b(mb[0]), .mac_valid_in(mvi[0]), .mac_f(mf[0])
  );
  fc_mac_arbiter #(.RELU(0)) u_dut_nr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready_nr),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready_nr),
    .res_valid(res_valid_nr), .res_data(res_data_nr), .res_ready(res_ready),
    .mac_clear(mclr[1]), .mac_a(ma[1]), .mac_b(mb[1]), .mac_valid_in(mvi[1]), .mac_f(mf[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sat(input logic [15:0] x, input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(x)) + int'($signed(a)) * int'($signed(b));
    return s > 32767 ? 16'h7fff : s < -32768 ? 16'h8000 : 16'(s);
  endfunction

  // accumulator visible one cycle after the term, final sum at mac_f two cycles later
  always_ff @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (mclr[k]) begin
        acc[k] <= '0;
        p1[k] <= '0;
        mf[k] <= '0;
      end else begin
        if (mvi[k]) acc[k] <= sat(acc[k], ma[k], mb[k]);
        p1[k] <= acc[k];
        mf[k] <= p1[k];
      end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_job(input string tag, input int r, input int n, input int a[3], input int b[3],
                         input int bub, input int stall, input bit hold, input int exp_r, input int exp_nr);
    int g_cyc, first_t, last_t, i, gap, oth;
    bit got;
    oth = 1 - r;
    req_valid[r] = 1;
    req_len[r] = 8'(n);
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      got = |req_ready;
      if (!got) @(negedge clk);
    end
    chk({tag, "_grant_seen"}, int'(got), 1);
    chk({tag, "_grant"}, int'(req_ready), 1 << r);
    g_cyc = cyc;
    @(negedge clk);
    if (!hold) req_valid[r] = 0;
    #1;
    chk({tag, "_clear"}, int'(mclr), 3);
    i = 0;
    gap = 0;
    first_t = -1;
    last_t = g_cyc + 1;
    for (int c = 0; c < 200 && i < n; c++) begin
      @(negedge clk);
      if (gap > 0) begin
        op_valid[r] = 0;
        gap--;
      end else begin
        op_valid[r] = 1;
        op_a[r] = 16'(a[i]);
        op_b[r] = 16'(b[i]);
      end
      #1;
      chk({tag, "_opr_other"}, int'(op_ready[oth]), 0);
      if (op_valid[r] && op_ready[r]) begin
        if (first_t < 0) first_t = cyc;
        last_t = cyc;
        i++;
        gap = bub;
      end
    end
    if (n > 0) begin
      chk({tag, "_nterms"}, i, n);
      chk({tag, "_first_op"}, first_t - g_cyc, 2);
      @(negedge clk);
      op_valid[r] = 1;
      op_a[r] = 16'd100;
      op_b[r] = 16'd100;
      #1;
      chk({tag, "_extra_op"}, int'({op_ready[r], mvi[0]}), 0);
    end
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      op_valid[r] = 0;
      got = res_valid[r];
    end
    chk({tag, "_res_seen"}, int'(got), 1);
    chk({tag, "_latency"}, n > 0 ? cyc - last_t : cyc - g_cyc, n > 0 ? MAC_LAT + 1 : MAC_LAT + 2);
    chk({tag, "_res"}, int'($signed(res_data)), exp_r);
    chk({tag, "_res_norelu"}, int'($signed(res_data_nr)), exp_nr);
    chk({tag, "_rv"}, int'(res_valid), 1 << r);
    chk({tag, "_rv_norelu"}, int'(res_valid_nr), 1 << r);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_rv"}, int'(res_valid), 1 << r);
      chk({tag, "_stall_rd"}, int'($signed(res_data)), exp_r);
      chk({tag, "_stall_nogrant"}, int'(req_ready), 0);
    end
    res_ready[r] = 1;
    @(negedge clk);
    res_ready[r] = 0;
    chk({tag, "_rv_drop"}, int'(res_valid), 0);
  endtask

  initial begin
    bit got;
    reset = 1;
    req_valid = '0;
    req_len = '0;
    op_valid = '0;
    op_a = '0;
    op_b = '0;
    res_ready = '0;
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_op_ready", int'(op_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_mac_vin", int'(mvi[0]), 0);
    chk("rst_mac_ab", int'({ma[0], mb[0]}), 0);
    chk("rst_mac_clear", int'(mclr[0]), 1);
    req_valid = '0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    // both requesters held the whole time: strict 0,1,0,1 rotation
    req_valid = 2'b11;
    req_len[0] = 8'd2;
    req_len[1] = 8'd2;
    run_job("rot0a", 0, 2, '{1, 3, 0}, '{2, 4, 0}, 0, 0, 1, 14, 14);
    run_job("rot1a", 1, 2, '{5, -7, 0}, '{6, 2, 0}, 0, 0, 1, 16, 16);
    run_job("rot0b", 0, 2, '{-3, 2, 0}, '{3, 2, 0}, 0, 0, 1, 0, -5);
    run_job("rot1b", 1, 2, '{10, 1, 0}, '{10, 1, 0}, 0, 0, 0, 101, 101);
    req_valid = '0;
    @(negedge clk);
    run_job("basic", 0, 3, '{2, 4, -1}, '{3, 5, 6}, 0, 0, 0, 20, 20);
    run_job("sat", 0, 2, '{200, 200, 0}, '{200, 200, 0}, 0, 0, 0, 32767, 32767);
    run_job("relu", 0, 1, '{-50, 0, 0}, '{10, 0, 0}, 0, 0, 0, 0, -500);
    // requester 0 waits during requester 1's stalled job and must not be granted early
    req_valid[0] = 1;
    req_len[0] = 8'd1;
    run_job("stall", 1, 3, '{3, 5, -2}, '{4, 6, 7}, 2, 5, 0, 28, 28);
    run_job("after_stall", 0, 1, '{3, 0, 0}, '{3, 0, 0}, 0, 0, 0, 9, 9);
    run_job("len0", 0, 0, '{0, 0, 0}, '{0, 0, 0}, 0, 0, 0, 0, 0);
    req_valid[0] = 1;
    req_len[0] = 8'd3;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      got = req_ready[0];
      if (!got) @(negedge clk);
    end
    chk("abort_grant", int'(got), 1);
    @(negedge clk);
    req_valid[0] = 0;
    @(negedge clk);
    op_valid[0] = 1;
    op_a[0] = 16'd9;
    op_b[0] = 16'd9;
    @(negedge clk);
    op_a[0] = 16'd5;
    op_b[0] = 16'd5;
    #1;
    chk("abort_streaming", int'(mvi[0]), 1);
    reset = 1;
    #1;
    chk("abort_req_ready", int'(req_ready), 0);
    chk("abort_op_ready", int'(op_ready), 0);
    chk("abort_res_valid", int'(res_valid), 0);
    chk("abort_res_data", int'(res_data), 0);
    chk("abort_mac_vin", int'(mvi[0]), 0);
    chk("abort_mac_ab", int'({ma[0], mb[0]}), 0);
    chk("abort_mac_clear", int'(mclr[0]), 1);
    @(negedge clk);
    reset = 0;
    op_valid = '0;
    @(negedge clk);
    run_job("post_abort", 0, 2, '{1, 2, 0}, '{7, 3, 0}, 0, 0, 0, 13, 13);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fc_mac_arbiter.md
# fc_mac_arbiter

Round-robin scheduler that shares one saturating MAC (the `mac` unit used by the fc layers) between N_REQ fc-layer controllers. Each requester asks for one dot-product job of `req_len` terms. The arbiter grants whole jobs, clears the MAC, streams the winner's operands into it, waits out the MAC pipeline, and returns the optional-ReLU result to the winner. It sits between the per-layer control FSMs and a single shared `mac` instance.

## Interface
- WIDTH, 16, operand/result width (signed)
- N_REQ, 2, number of requesters (≥2)
- LEN_W, 8, width of job length field
- MAC_LAT, 3, cycles from last `mac_valid_in` cycle until `mac_f` holds the final sum
- RELU, 1, 1 = clamp negative results to 0
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  [N_REQ]  job request; held until accepted
- req_len  in  [N_REQ][LEN_W]  number of terms in the job
- req_ready  out  [N_REQ]  one-hot job grant
- op_valid  in  [N_REQ]  operand pair valid
- op_a, op_b  in  [N_REQ][WIDTH]  operand pair
- op_ready  out  [N_REQ]  operand accepted
- res_valid  out  [N_REQ]  result valid, one-hot
- res_data  out  WIDTH  result, shared bus
- res_ready  in  [N_REQ]  result consumed
- mac_clear  out  1  to the MAC reset
- mac_a, mac_b  out  WIDTH  to MAC a/b
- mac_valid_in  out  1  to MAC valid_in
- mac_f  in  WIDTH  MAC accumulator output

## Operation
- FSM states: IDLE, CLEAR, STREAM, DRAIN, RESULT. Registers: `g` (granted index), `len`, `cnt` (LEN_W+1 bits), `dcnt`, `last_grant`, `res_q`.
- IDLE:
  - Priority search starts at `last_grant+1` (mod N_REQ) and picks the first asserted `req_valid`.
  - `req_ready[pick]=1` combinationally, so the grant handshake completes in the same cycle.
  - On grant: latch `g` and `len`, then go to CLEAR.
- CLEAR: `mac_clear=1` for exactly one cycle; `cnt←0`. Next state is STREAM, or DRAIN directly if `len==0`.
- STREAM:
  - `op_ready[g]=1`; all other `op_ready` are 0.
  - `mac_a=op_a[g]`, `mac_b=op_b[g]`, `mac_valid_in=op_valid[g]`, all combinational pass-through.
  - Each handshake increments `cnt`. A low `op_valid` is a bubble: no MAC update.
  - On the handshake where `cnt+1==len`, set `dcnt←MAC_LAT` and go to DRAIN.
- DRAIN:
  - `dcnt` decrements each cycle.
  - In the cycle `dcnt==1`: `res_q ← (RELU && mac_f<0) ? 0 : mac_f`, then go to RESULT.
- RESULT:
  - `res_valid[g]=1`, `res_data=res_q`, both stable until `res_ready[g]`.
  - On handshake: `last_grant←g`, go to IDLE. No new grant is issued while in RESULT.
- Arithmetic: saturation is performed by the MAC. The arbiter never modifies `mac_f` except for the ReLU clamp.
- When not in the state that drives them, `mac_a`/`mac_b`/`mac_valid_in` are 0 and `mac_clear` is 0.

## Timing
- Reset values:
  - state IDLE; `last_grant=N_REQ-1`, so requester 0 wins first after reset.
  - All `req_ready`/`op_ready`/`res_valid`/`mac_valid_in` = 0; `res_data=0`; `mac_a=mac_b=0`.
  - `mac_clear=1` combinationally while `reset` is asserted.
- Reset mid-job aborts the job: no result is produced and the requester must re-request.
- Grant cycle G → CLEAR at G+1 → first operand can be accepted at G+2.
- Last operand accepted in cycle T → DRAIN in T+1..T+MAC_LAT → `res_valid` rises at T+MAC_LAT+1.
- `len==0`: CLEAR → DRAIN; the result is 0 (the MAC was cleared). `res_valid` at G+MAC_LAT+2.
- Simultaneous requests: strict rotation. With all requesters always asserting, grants cycle 0,1,…,N_REQ-1,0.
- `req_valid` dropping while not granted is legal; it has no effect.
- Extra `op_valid` after `len` terms is ignored, because `op_ready` is 0.

## Structure
- Package `fc_pkg`: `arb_state_t` enum (IDLE, CLEAR, STREAM, DRAIN, RESULT), default `N_REQ`/`WIDTH`/`MAC_LAT` constants.
- Sub-module `fc_rr_picker`: combinational rotate-priority encoder. Inputs are the request vector and `last_grant`; outputs are a one-hot pick and an any-request flag.
- The shared `mac` instance is outside this block; the bench instantiates it.

## Test plan
- req0 len=3, terms (2,3),(4,5),(-1,6) with no bubbles → `res_data=20`, `res_valid[0]` exactly 4 cycles after the last accepted term.
- req0 and req1 both held continuously, len=2 each → grant order 0,1,0,1. Each result equals that requester's own dot product; `op_ready` is never asserted for the non-granted requester.
- Saturation/ReLU:
  - Terms (200,200),(200,200) → result 32767.
  - RELU=1, terms (-50,10) → result 0.
  - RELU=0, terms (-50,10) → result -500.
- Stalls: `op_valid` bubbles of 2 cycles between terms, `res_ready` held low for 5 cycles → same sum; `res_valid`/`res_data` are stable; no new grant appears during the stall.
- len=0 request → `res_data=0` at G+MAC_LAT+2.
- Reset asserted mid-STREAM → all outputs are at their reset values immediately. The next job's (1,7),(2,3) → 13, unaffected by the aborted job.
